pkt_task_scheduler: RTL and testbench
=====================================

// Module: pkt_task_scheduler
// PURPOSE
//  Sits between the packet filter and the per-packet task units (MNI, KCH, reward, QTU).
//  - Queues each new packet's task-enable set.
//  - Runs the enabled tasks one at a time, in a fixed order, with a start/done handshake.
//  - Gives the task unit it is running exclusive ownership of the shared node-memory port.
// PARAMETERS
//  FIFO_DEPTH   4    pending-packet entries (power of 2, >=2)
//  WD_CYCLES    256  watchdog limit in WAIT; used only with TASK_WATCHDOG_EN
//  DROP_W       8    width of the dropped-packet counter
// PORTS
//  clk            in   1       system clock, rising edge
//  nrst           in   1       asynchronous active-low reset
//  newpkt         in   1       one-cycle strobe, packet filtered this cycle
//  en_MNI         in   1       task request: my-neighbour-info update
//  en_KCH         in   1       task request: cluster-head handling
//  en_reward      in   1       task request: reward computation
//  en_QTU         in   1       task request: Q-table update
//  iAmDestination in   1       packet addressed to this node; queued with the mask
//  taskDone       in   4       per-unit done pulse {QTU,reward,KCH,MNI}
//  taskStart      out  4       one-hot, one-cycle start pulse to the unit
//  memGrant       out  4       one-hot shared-memory ownership
//  curIsDest      out  1       iAmDestination of the packet in service
//  pktReady       out  1       FIFO not full
//  busy           out  1       FSM not IDLE or FIFO not empty
//  dropCount      out  DROP_W  saturating count of dropped packets
//  wdTimeout      out  1       sticky watchdog flag (0 when feature is compiled out)
// BEHAVIOUR
//  Reset: all outputs 0 except pktReady=1. FIFO empty, FSM IDLE, dropCount=0.
//  Reset mid-operation: pending and in-service work is discarded; no start or grant is held.
//  Push, sampled at the edge where newpkt=1:
//   - mask={en_QTU,en_reward,en_KCH,en_MNI}.
//   - mask==0: ignored; not counted as a drop.
//   - FIFO full: packet dropped; dropCount+1, saturating at all-ones.
//   - Full is evaluated before any same-cycle pop: a push to a full FIFO drops even when a pop
//     occurs that cycle.
//  FSM (registered state):
//   IDLE  -> LOAD   when FIFO non-empty.
//   LOAD  : pop head into curMask/curIsDest -> START.
//   START : taskStart[i] and memGrant[i] high for one cycle.
//           i = lowest set bit of curMask; priority MNI > KCH > reward > QTU -> WAIT.
//   WAIT  : memGrant[i] held high.
//           On taskDone[i]: clear curMask[i]; -> START if curMask is still nonzero, else IDLE.
//  Latency: newpkt sampled at edge E0 into an IDLE block with an empty FIFO -> LOAD after E1,
//   START after E2. taskStart is high from E2 to E3.
//  Handshakes and grant:
//   - taskDone is sampled only in WAIT and only for the granted unit; other bits are ignored.
//   - A done pulse that coincides with START is ignored.
//   - memGrant drops in the cycle after done; at most one grant bit is ever high.
//   - A unit never receives a second start for the same packet.
// CONFIGURATION
//  TASK_WATCHDOG_EN defined:
//   - A counter clears on entry to WAIT and increments each WAIT cycle.
//   - When it reaches WD_CYCLES-1 with no done: abort the task, clear its curMask bit,
//     set wdTimeout (sticky until reset), then continue as if done.
//  TASK_WATCHDOG_EN undefined:
//   - No counter; WAIT holds indefinitely; wdTimeout tied to 0.
// STRUCTURE
//  eer_sched_pkg:
//   - state enum {IDLE,LOAD,START,WAIT}
//   - task index constants T_MNI=0, T_KCH=1, T_RWD=2, T_QTU=3
//   - TASK_N=4; entry layout {isDest, mask[3:0]}
//  Sub-module pkt_task_fifo: synchronous FIFO, 5-bit entries, depth FIFO_DEPTH.
//   - full/empty from ptr+wrap bit.
//   - Pointers wrap at FIFO_DEPTH without loss.
//  Top level holds FSM, priority encoder, drop counter and watchdog.
// TESTING
//  1 Heartbeat: mask=MNI|reward -> start[0]; done[0] after 3 cycles -> start[2]; done[2] -> IDLE,
//    busy=0.
//  2 Back-to-back: push 6 masks=4'b0001 while done is held off (FIFO_DEPTH=4; the first is in
//    service) -> 1 dropped; dropCount=1; pktReady=0 while full.
//  3 Stray done: done[1] while grant[0] -> ignored; done[0] in START -> ignored; grant stays
//    one-hot.
//  4 Reset mid-WAIT: nrst=0 for 1 cycle -> all outputs 0, pktReady=1, queued packets lost.
//  5 Watchdog (EN, WD_CYCLES=8): withhold done -> abort after 8 WAIT cycles, wdTimeout=1,
//    next task started.
//  6 Saturation: 300 drops with DROP_W=8 -> dropCount=255.

Source files
------------

// File: rtl/eer_sched_pkg.sv
// Shared types for the packet task scheduler.
// Task order, FIFO entry layout and FSM states.
package eer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    WAIT
  } state_e;

  localparam int TASK_N = 4;
  localparam int T_MNI  = 0;
  localparam int T_KCH  = 1;
  localparam int T_RWD  = 2;
  localparam int T_QTU  = 3;

  typedef struct packed {
    logic              is_dest;
    logic [TASK_N-1:0] mask;
  } entry_t;

  // Lowest set bit wins: MNI > KCH > reward > QTU.
  function automatic logic [TASK_N-1:0] lsb_onehot(
    input logic [TASK_N-1:0] m
  );
    return m & (-m);
  endfunction

endpackage

// File: rtl/pkt_task_fifo.sv
// Pending-packet FIFO for the task scheduler.
// Pointers carry a wrap bit so full and empty are unambiguous.
module pkt_task_fifo
  import eer_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   nrst,
  input  logic   push_i,
  input  entry_t din_i,
  input  logic   pop_i,
  output entry_t dout_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  entry_t      mem_q [DEPTH];

  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o)
        wr_q <= wr_q + 1'b1;
      if (pop_i && !empty_o)
        rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o)
      mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/pkt_task_scheduler.sv
// Serialises per-packet tasks and owns the shared node-memory grant.
// Optional WAIT watchdog compiled in with TASK_WATCHDOG_EN.
module pkt_task_scheduler
  import eer_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WD_CYCLES  = 256,
  parameter int DROP_W     = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              newpkt,
  input  logic              en_MNI,
  input  logic              en_KCH,
  input  logic              en_reward,
  input  logic              en_QTU,
  input  logic              iAmDestination,
  input  logic [TASK_N-1:0] taskDone,
  output logic [TASK_N-1:0] taskStart,
  output logic [TASK_N-1:0] memGrant,
  output logic              curIsDest,
  output logic              pktReady,
  output logic              busy,
  output logic [DROP_W-1:0] dropCount,
  output logic              wdTimeout
);

  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end
  if (WD_CYCLES < 2) begin : g_bad_wd
    $error("WD_CYCLES must be >= 2");
  end

  state_e            state_q;
  state_e            state_d;
  logic [TASK_N-1:0] cur_mask_q;
  logic              cur_dest_q;
  logic [DROP_W-1:0] drop_q;

  entry_t            f_din;
  entry_t            f_dout;
  logic              f_full;
  logic              f_empty;
  logic              push_req;
  logic [TASK_N-1:0] grant_oh;
  logic              done_hit;
  logic              finish;

  always_comb begin
    f_din              = '0;
    f_din.is_dest      = iAmDestination;
    f_din.mask[T_MNI]  = en_MNI;
    f_din.mask[T_KCH]  = en_KCH;
    f_din.mask[T_RWD]  = en_reward;
    f_din.mask[T_QTU]  = en_QTU;
  end

  assign push_req = newpkt && (f_din.mask != '0);
  assign grant_oh = lsb_onehot(cur_mask_q);
  assign done_hit = (state_q == WAIT) &&
                    ((taskDone & grant_oh) != '0);

  pkt_task_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push_i  (push_req),
    .din_i   (f_din),
    .pop_i   (state_q == LOAD),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

`ifdef TASK_WATCHDOG_EN
  localparam int WDW = $clog2(WD_CYCLES) + 1;

  logic [WDW-1:0] wd_q;
  logic           wd_flag_q;
  logic           wd_hit;

  assign wd_hit = (state_q == WAIT) &&
                  (wd_q == WDW'(WD_CYCLES - 1));
  assign finish = done_hit || wd_hit;
  assign wdTimeout = wd_flag_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wd_q      <= '0;
      wd_flag_q <= 1'b0;
    end else begin
      if (state_q == START)
        wd_q <= '0;
      else if (state_q == WAIT)
        wd_q <= wd_q + 1'b1;
      if (wd_hit && !done_hit)
        wd_flag_q <= 1'b1;
    end
  end
`else
  assign finish    = done_hit;
  assign wdTimeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!f_empty) state_d = LOAD;
      LOAD:  state_d = START;
      START: state_d = WAIT;
      WAIT:
        if (finish)
          state_d = ((cur_mask_q & ~grant_oh) != '0)
                    ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    taskStart = '0;
    memGrant  = '0;
    unique case (state_q)
      START: begin
        taskStart = grant_oh;
        memGrant  = grant_oh;
      end
      WAIT:    memGrant = grant_oh;
      default: ;
    endcase
  end

  // Full is judged before the same-edge pop, so a push to a full FIFO drops.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur_mask_q <= '0;
      cur_dest_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (state_q == LOAD) begin
        cur_mask_q <= f_dout.mask;
        cur_dest_q <= f_dout.is_dest;
      end else if (state_q == WAIT && finish) begin
        cur_mask_q <= cur_mask_q & ~grant_oh;
      end
      if (push_req && f_full && drop_q != '1)
        drop_q <= drop_q + 1'b1;
    end
  end

  assign curIsDest = cur_dest_q;
  assign pktReady  = !f_full;
  assign busy      = (state_q != IDLE) || !f_empty;
  assign dropCount = drop_q;

endmodule

// File: tb/tb_pkt_task_scheduler.sv
// Self-checking bench for pkt_task_scheduler: vector table,
// directed corner sequences and a random run against a queue model.
module tb_pkt_task_scheduler;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       newpkt = 1'b0;
  logic       en_MNI = 1'b0;
  logic       en_KCH = 1'b0;
  logic       en_reward = 1'b0;
  logic       en_QTU = 1'b0;
  logic       iAmDestination = 1'b0;
  logic [3:0] taskDone = 4'b0;
  logic [3:0] taskStart;
  logic [3:0] memGrant;
  logic       curIsDest;
  logic       pktReady;
  logic       busy;
  logic [7:0] dropCount;
  logic       wdTimeout;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pkt_task_scheduler dut (
    .clk            (clk),
    .nrst           (nrst),
    .newpkt         (newpkt),
    .en_MNI         (en_MNI),
    .en_KCH         (en_KCH),
    .en_reward      (en_reward),
    .en_QTU         (en_QTU),
    .iAmDestination (iAmDestination),
    .taskDone       (taskDone),
    .taskStart      (taskStart),
    .memGrant       (memGrant),
    .curIsDest      (curIsDest),
    .pktReady       (pktReady),
    .busy           (busy),
    .dropCount      (dropCount),
    .wdTimeout      (wdTimeout)
  );

  typedef struct {
    logic [3:0]  mask;
    logic        dest;
    logic [15:0] seq;
    int          n;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic put(input logic np, input logic [3:0] m,
                     input logic d);
    newpkt = np;
    {en_QTU, en_reward, en_KCH, en_MNI} = m;
    iAmDestination = d;
  endtask

  task automatic do_reset();
    put(1'b0, 4'b0, 1'b0);
    taskDone = 4'b0;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  // Task order: first enabled one in MNI, KCH, reward, QTU order.
  function automatic logic [3:0] first_task(input logic [3:0] rem);
    logic [3:0] r;
    r = 4'b0;
    for (int i = 0; i < 4; i++)
      if (rem[i]) begin
        r[i] = 1'b1;
        return r;
      end
    return r;
  endfunction

  logic [3:0] cur_rem, outst, rm;
  logic [4:0] ent;
  logic [4:0] q[$];
  logic       cur_dest, done_pend, in_start, seen, rd;
  int         delay, drops, stall, cnt;

  initial begin
    vt[0] = '{4'b0101, 1'b1, 16'h1400, 2};
    vt[1] = '{4'b0001, 1'b0, 16'h1000, 1};
    vt[2] = '{4'b1111, 1'b0, 16'h1248, 4};
    vt[3] = '{4'b1010, 1'b1, 16'h2800, 2};
    vt[4] = '{4'b1000, 1'b1, 16'h8000, 1};
    vt[5] = '{4'b0110, 1'b0, 16'h2400, 2};
    vt[6] = '{4'b1100, 1'b1, 16'h4800, 2};
    vt[7] = '{4'b1001, 1'b0, 16'h1800, 2};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_start", taskStart, 0);
    chk("rst_grant", memGrant, 0);
    chk("rst_dest", curIsDest, 0);
    chk("rst_ready", pktReady, 1);
    chk("rst_busy", busy, 0);
    chk("rst_drop", dropCount, 0);
    chk("rst_wd", wdTimeout, 0);
    nrst = 1'b1;
    @(negedge clk);

    // vector table: latency, order, stray and START-time done
    for (int v = 0; v < 8; v++) begin
      put(1'b1, vt[v].mask, vt[v].dest);
      @(negedge clk);
      put(1'b0, 4'b0, 1'b0);
      chk("lat_busy", busy, 1);
      chk("lat_e1", taskStart, 0);
      @(negedge clk);
      chk("lat_e2", taskStart, 0);
      @(negedge clk);
      for (int k = 0; k < vt[v].n; k++) begin
        logic [3:0] e;
        e = vt[v].seq[15-4*k -: 4];
        chk("v_start", taskStart, e);
        chk("v_grant", memGrant, e);
        chk("v_dest", curIsDest, vt[v].dest);
        taskDone = e;
        @(negedge clk);
        taskDone = ~e;
        chk("v_done_in_start", taskStart, 0);
        chk("v_wgrant", memGrant, e);
        @(negedge clk);
        taskDone = 4'b0;
        chk("v_stray", memGrant, e);
        @(negedge clk);
        taskDone = e;
        @(negedge clk);
        taskDone = 4'b0;
      end
      chk("v_end_grant", memGrant, 0);
      chk("v_end_busy", busy, 0);
    end

    // back-to-back pushes into a full FIFO
    for (int i = 0; i < 6; i++) begin
      put(1'b1, 4'b0001, 1'b0);
      @(negedge clk);
    end
    put(1'b0, 4'b0, 1'b0);
    chk("bb_drop", dropCount, 1);
    chk("bb_full", pktReady, 0);
    chk("bb_svc", memGrant, 4'b0001);
    taskDone = 4'b0001;
    @(negedge clk);
    taskDone = 4'b0;
    for (int p = 0; p < 4; p++) begin
      int w;
      w = 0;
      while (taskStart == 4'b0 && w < 10) begin
        @(negedge clk);
        w++;
      end
      chk("bb_start", taskStart, 4'b0001);
      @(negedge clk);
      taskDone = 4'b0001;
      @(negedge clk);
      taskDone = 4'b0;
    end
    chk("bb_busy", busy, 0);
    chk("bb_drop2", dropCount, 1);

    // reset in WAIT discards everything
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 4'b0011, 1'b1);
      @(negedge clk);
    end
    put(1'b0, 4'b0, 1'b0);
    chk("rw_start", taskStart, 4'b0001);
    @(negedge clk);
    chk("rw_wait", memGrant, 4'b0001);
    nrst = 1'b0;
    #1;
    chk("rw_grant", memGrant, 0);
    chk("rw_dest", curIsDest, 0);
    chk("rw_busy0", busy, 0);
    chk("rw_ready", pktReady, 1);
    chk("rw_drop", dropCount, 0);
    @(negedge clk);
    nrst = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (taskStart != 4'b0 || memGrant != 4'b0) seen = 1'b1;
    end
    chk("rw_lost", seen, 0);
    chk("rw_busy", busy, 0);

    // withheld done
    put(1'b1, 4'b0011, 1'b0);
    @(negedge clk);
    put(1'b0, 4'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("hd_start", taskStart, 4'b0001);
    chk("hd_wd0", wdTimeout, 0);
`ifdef TASK_WATCHDOG_EN
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (taskStart == 4'b0 && cnt < 400);
    chk("wd_cycles", cnt, 257);
    chk("wd_next", taskStart, 4'b0010);
    chk("wd_flag", wdTimeout, 1);
    @(negedge clk);
    taskDone = 4'b0010;
    @(negedge clk);
    taskDone = 4'b0;
    chk("wd_busy", busy, 0);
    chk("wd_sticky", wdTimeout, 1);
`else
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (taskStart != 4'b0) seen = 1'b1;
    end
    chk("hd_nostart", seen, 0);
    chk("hd_grant", memGrant, 4'b0001);
    chk("hd_wd", wdTimeout, 0);
    taskDone = 4'b0001;
    @(negedge clk);
    taskDone = 4'b0;
    chk("hd_next", taskStart, 4'b0010);
    @(negedge clk);
    taskDone = 4'b0010;
    @(negedge clk);
    taskDone = 4'b0;
    chk("hd_busy", busy, 0);
`endif

    // drop counter saturation
    do_reset();
    for (int i = 0; i < 259; i++) begin
      put(1'b1, 4'b0001, 1'b0);
      @(negedge clk);
    end
    put(1'b0, 4'b0, 1'b0);
    chk("sat_254", dropCount, 254);
    chk("sat_full", pktReady, 0);
    for (int i = 0; i < 46; i++) begin
      put(1'b1, 4'b0100, 1'b0);
      @(negedge clk);
    end
    put(1'b0, 4'b0, 1'b0);
    chk("sat_255", dropCount, 255);

    // random traffic against the queue model
    do_reset();
    chk("rnd_rst_drop", dropCount, 0);
    cur_rem = 4'b0;
    outst = 4'b0;
    cur_dest = 1'b0;
    done_pend = 1'b0;
    in_start = 1'b0;
    drops = 0;
    stall = 0;
    delay = 0;
    q.delete();
    repeat (3000) begin
      @(negedge clk);
      if (done_pend) begin
        cur_rem = cur_rem & ~outst;
        outst = 4'b0;
        done_pend = 1'b0;
      end
      if (outst == 4'b0 && cur_rem != 4'b0) begin
        chk("r_next", taskStart, first_task(cur_rem));
        chk("r_dest", curIsDest, cur_dest);
        outst = first_task(cur_rem);
        in_start = 1'b1;
        delay = $urandom_range(1, 6);
      end else if (taskStart != 4'b0) begin
        if (outst != 4'b0 || q.size() == 0) begin
          chk("r_spurious", taskStart, 0);
        end else begin
          ent = q.pop_front();
          cur_rem = ent[3:0];
          cur_dest = ent[4];
          chk("r_first", taskStart, first_task(cur_rem));
          chk("r_dest", curIsDest, cur_dest);
          outst = first_task(cur_rem);
          in_start = 1'b1;
          delay = $urandom_range(1, 6);
        end
      end
      if (outst == 4'b0 && cur_rem == 4'b0 && q.size() > 0)
        stall++;
      else
        stall = 0;
      if (stall > 2) begin
        chk("r_latency", stall, 2);
        stall = 0;
      end
      chk("r_grant", memGrant, outst);
      chk("r_busy", busy, (q.size() > 0 || cur_rem != 4'b0));
      chk("r_ready", pktReady, (q.size() < 4));
      chk("r_drop", dropCount, drops);
      chk("r_wd", wdTimeout, 0);

      taskDone = 4'b0;
      if (outst != 4'b0) begin
        if (in_start) begin
          in_start = 1'b0;
          if ($urandom_range(0, 3) == 0) taskDone = outst;
        end else begin
          delay--;
          if (delay == 0) begin
            taskDone = outst;
            done_pend = 1'b1;
          end
        end
      end
      if ($urandom_range(0, 2) == 0)
        taskDone = taskDone | (4'($urandom) & ~outst);

      rm = 4'($urandom);
      rd = 1'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        put(1'b1, rm, rd);
        if (rm != 4'b0) begin
          if (q.size() >= 4) begin
            if (drops < 255) drops++;
          end else begin
            q.push_back({rd, rm});
          end
        end
      end else begin
        put(1'b0, 4'b0, 1'b0);
      end
    end
    put(1'b0, 4'b0, 1'b0);
    taskDone = 4'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
